dmem_arbiter: RTL and testbench

- Arbitrates the single-port 32x8 data memory between two requesters:
  - the CPU control path, for LDA/STO/ALU operand fetches;
  - an external loader/debug port that runs programmed bursts to preload or dump data memory.
- Sits between the CPU datapath and the data MEM instance and drives the memory's en/we/addr/din.
- CPU has fixed priority. Loader bursts are paused beat by beat while the CPU is using the memory.

---
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the memory.
// slave = arbiter side, master = requester/memory side.
interface dmem_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;

    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_base;
    logic [AW:0]   ld_len;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt;
    logic          ld_rvalid;
    logic          ld_done;
    logic          busy;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic [DW-1:0] rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ld_req, ld_we, ld_base, ld_len, ld_wdata,
        input  mem_dout,
        output cpu_gnt, cpu_rvalid,
        output ld_gnt, ld_rvalid, ld_done, busy,
        output mem_en, mem_we, mem_addr, mem_din, rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ld_req, ld_we, ld_base, ld_len, ld_wdata,
        output mem_dout,
        input  cpu_gnt, cpu_rvalid,
        input  ld_gnt, ld_rvalid, ld_done, busy,
        input  mem_en, mem_we, mem_addr, mem_din, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU has fixed priority, loader bursts advance beat by beat.
// Optional ARB_STARVE_GUARD_EN forces a loader beat after MAX_WAIT blocked cycles.
module dmem_arbiter #(
    parameter int AW       = 5,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};
    localparam int          WAIT_W  = $clog2(MAX_WAIT + 1);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          we_q, we_d;
    logic          cpu_rvalid_q, cpu_rvalid_d;
    logic          ld_rvalid_q, ld_rvalid_d;

    logic [AW:0]     len_clamped;
    logic            cpu_gnt, ld_gnt, force_ld;
    logic [WAIT_W-1:0] wait_cnt;
    logic            mem_en, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_din;

`ifdef ARB_STARVE_GUARD_EN
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q != S_BURST || ld_gnt)
            wait_cnt_d = '0;
        else if (bus.cpu_req)
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wait_cnt_q <= '0;
        else      wait_cnt_q <= wait_cnt_d;
    end

    assign wait_cnt = wait_cnt_q;
`else
    // No counter: tied low, so the guard comparison below never fires.
    assign wait_cnt = '0;
`endif

    // Grants and memory drive are purely combinational; reset masks the CPU path.
    always_comb begin
        len_clamped = (bus.ld_len > MAX_LEN) ? MAX_LEN : bus.ld_len;
        force_ld    = (state_q == S_BURST) && (wait_cnt == WAIT_W'(MAX_WAIT));
        cpu_gnt     = rst && bus.cpu_req && !force_ld;
        ld_gnt      = rst && (state_q == S_BURST) && (!bus.cpu_req || force_ld);

        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = {DW{1'b0}};
        if (cpu_gnt) begin
            mem_en   = 1'b1;
            mem_we   = bus.cpu_we;
            mem_addr = bus.cpu_addr;
            mem_din  = bus.cpu_wdata;
        end else if (ld_gnt) begin
            mem_en   = 1'b1;
            mem_we   = we_q;
            mem_addr = ptr_q;
            mem_din  = bus.ld_wdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        cpu_rvalid_d = cpu_gnt && !bus.cpu_we;
        ld_rvalid_d  = ld_gnt && !we_q;

        case (state_q)
            S_IDLE: begin
                if (bus.ld_req) begin
                    we_d    = bus.ld_we;
                    ptr_d   = bus.ld_base;
                    cnt_d   = len_clamped;
                    state_d = (len_clamped == '0) ? S_DONE : S_BURST;
                end
            end
            S_BURST: begin
                if (ld_gnt) begin
                    ptr_d = ptr_q + AW'(1);
                    cnt_d = cnt_q - (AW+1)'(1);
                    if (cnt_q == (AW+1)'(1))
                        state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            ld_rvalid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            ld_rvalid_q  <= ld_rvalid_d;
        end
    end

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.ld_gnt     = ld_gnt;
    assign bus.ld_rvalid  = ld_rvalid_q;
    assign bus.ld_done    = (state_q == S_DONE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.mem_en     = mem_en;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_din    = mem_din;
    assign bus.rdata      = bus.mem_dout;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: driver pushes expectations, negedge monitor checks
// them against a transaction-level model of the arbitration rules and a shadow memory.
module tb_dmem_arbiter;
    localparam int AW = 5, DW = 8, MAX_WAIT = 4, N = 32;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Synchronous-read memory the arbiter drives.
    logic [7:0] mem [N];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
            bus.mem_dout <= mem[bus.mem_addr];
        end
    end

    int total = 0, bad = 0;
    int gnt_cnt = 0, done_cnt = 0, lrv_cnt = 0;
    logic [7:0]  ref_mem [N];
    logic [7:0]  wbuf [N];
    int          widx;
    logic [7:0]  cpu_exp [$];
    logic [7:0]  ld_data_q [$];
    logic [13:0] beat_q [$];   // {we, addr, wdata}

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Model state: a burst is "active" from the cycle after its request through its done cycle.
    bit m_active, m_we, m_prev_cpu_rd, m_prev_ld_rd;
    int m_left, m_wait;
    bit e_force, e_cpu, e_ld;
    logic [13:0] bt;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("reset_outs", {bus.cpu_gnt, bus.ld_gnt, bus.mem_en, bus.busy, bus.ld_done,
                               bus.cpu_rvalid, bus.ld_rvalid}, 0);
            m_active = 0; m_left = 0; m_wait = 0; m_prev_cpu_rd = 0; m_prev_ld_rd = 0;
            cpu_exp.delete(); ld_data_q.delete(); beat_q.delete();
        end else begin
            e_force = GUARD && m_active && m_left > 0 && m_wait == MAX_WAIT;
            e_cpu   = bus.cpu_req && !e_force;
            e_ld    = m_active && m_left > 0 && (!bus.cpu_req || e_force);
            chk("cpu_gnt", bus.cpu_gnt, e_cpu);
            chk("ld_gnt", bus.ld_gnt, e_ld);
            chk("busy", bus.busy, m_active);
            chk("ld_done", bus.ld_done, m_active && m_left == 0);
            chk("cpu_rvalid", bus.cpu_rvalid, m_prev_cpu_rd);
            chk("ld_rvalid", bus.ld_rvalid, m_prev_ld_rd);
            chk("mem_en", bus.mem_en, e_cpu || e_ld);
            if (e_cpu) begin
                chk("cpu_mem_bus", {bus.mem_we, bus.mem_addr, bus.mem_din},
                    {bus.cpu_we, bus.cpu_addr, bus.cpu_wdata});
            end else if (e_ld) begin
                chk("beat_expected", beat_q.size() != 0, 1);
                if (beat_q.size() != 0) begin
                    bt = beat_q.pop_front();
                    chk("beat_we_addr", {bus.mem_we, bus.mem_addr}, bt[13:8]);
                    if (bt[13]) chk("beat_din", bus.mem_din, bt[7:0]);
                end
            end else begin
                chk("mem_idle", {bus.mem_we, bus.mem_addr, bus.mem_din}, 0);
            end
            if (bus.cpu_rvalid) begin
                chk("cpu_rd_expected", cpu_exp.size() != 0, 1);
                if (cpu_exp.size() != 0) chk("cpu_rdata", bus.rdata, cpu_exp.pop_front());
            end
            if (bus.ld_rvalid) begin
                lrv_cnt++;
                chk("ld_rd_expected", ld_data_q.size() != 0, 1);
                if (ld_data_q.size() != 0) chk("ld_rdata", bus.rdata, ld_data_q.pop_front());
            end
            if (bus.ld_gnt) gnt_cnt++;
            if (bus.ld_done) done_cnt++;

            m_prev_cpu_rd = e_cpu && !bus.cpu_we;
            m_prev_ld_rd  = e_ld && !m_we;
            if (e_ld) m_wait = 0;
            else if (m_active && m_left > 0 && bus.cpu_req) m_wait++;
            else m_wait = 0;
            if (m_active && m_left == 0) m_active = 0;
            else if (e_ld) m_left--;
            else if (!m_active && bus.ld_req) begin
                m_active = 1;
                m_we     = bus.ld_we;
                m_left   = (bus.ld_len > 6'd32) ? 32 : int'(bus.ld_len);
            end
        end
    end

    task automatic cpu_op(input logic we, input logic [4:0] a, input logic [7:0] d);
        bit got = 0;
        bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        if (we) ref_mem[a] = d;
        else cpu_exp.push_back(ref_mem[a]);
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = bus.cpu_gnt;
        end
        chk("cpu_gnt_wait", got, 1);
        tick();
        bus.cpu_req = 0; bus.cpu_we = 0;
    endtask

    task automatic ld_start(input logic we, input logic [4:0] base, input logic [5:0] len,
                            input bit fixed);
        int n;
        logic [4:0] a;
        n = (len > 6'd32) ? 32 : int'(len);
        for (int i = 0; i < n; i++) begin
            a = base + 5'(i);
            wbuf[i] = fixed ? 8'hA0 + 8'(i) : 8'($urandom);
            if (we) ref_mem[a] = wbuf[i];
            else ld_data_q.push_back(ref_mem[a]);
            beat_q.push_back({we, a, wbuf[i]});
        end
        widx = 0;
        bus.ld_wdata = wbuf[0];
        bus.ld_req = 1; bus.ld_we = we; bus.ld_base = base; bus.ld_len = len;
        tick();
        bus.ld_req = 0;
    endtask

    // Runs the burst to completion; optionally sprinkles CPU reads in between beats.
    task automatic ld_run(input bit mix);
        bit gs, cs, bsy, pend = 0, fin = 0;
        logic [4:0] a;
        for (int c = 0; c < 400 && !fin; c++) begin
            @(negedge clk);
            gs = bus.ld_gnt; cs = bus.cpu_gnt; bsy = bus.busy;
            tick();
            if (gs && bus.ld_we && widx < N - 1) begin
                widx++;
                bus.ld_wdata = wbuf[widx];
            end
            if (pend && cs) begin pend = 0; bus.cpu_req = 0; end
            if (!bsy && !pend) fin = 1;
            else if (mix && !pend && bsy && $urandom_range(0, 2) == 0) begin
                a = 5'($urandom);
                pend = 1; bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = a;
                cpu_exp.push_back(ref_mem[a]);
            end
        end
        chk("ld_run_finished", fin, 1);
    endtask

    task automatic burst(input logic we, input logic [4:0] base, input logic [5:0] len,
                         input bit fixed, input bit mix);
        int g0, d0, n;
        g0 = gnt_cnt; d0 = done_cnt;
        n = (len > 6'd32) ? 32 : int'(len);
        ld_start(we, base, len, fixed);
        ld_run(mix);
        chk("burst_beats", gnt_cnt - g0, n);
        chk("burst_done_once", done_cnt - d0, 1);
    endtask

    initial begin
        int g0, d0, l0, seen;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 5'd3; bus.cpu_wdata = 0;
        bus.ld_req = 0; bus.ld_we = 0; bus.ld_base = 0; bus.ld_len = 0; bus.ld_wdata = 0;
        repeat (2) @(negedge clk);
        tick();
        bus.cpu_req = 0;
        rst = 1;
        tick();

        cpu_op(1, 5'd5, 8'h3C);
        cpu_op(0, 5'd5, 8'h00);
        tick();

        burst(1, 5'd30, 6'd4, 1, 0);
        burst(1, 5'd0, 6'd40, 0, 0);   // clamps to a full 32-beat preload

        // CPU request lands on the second beat cycle of a read burst.
        l0 = lrv_cnt;
        ld_start(0, 5'd0, 6'd3, 0);
        @(negedge clk);
        tick();
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 5'd7;
        cpu_exp.push_back(ref_mem[7]);
        @(negedge clk);
        chk("pause_gnts", {bus.ld_gnt, bus.cpu_gnt}, 2'b01);
        tick();
        bus.cpu_req = 0;
        ld_run(0);
        chk("pause_rvalid_cnt", lrv_cnt - l0, 3);

        burst(0, 5'd9, 6'd0, 0, 0);

        // CPU holds its request for 12 burst cycles.
        g0 = gnt_cnt;
        ld_start(0, 5'd10, 6'd3, 0);
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 5'd2; bus.cpu_wdata = 8'h55;
        ref_mem[2] = 8'h55;
        repeat (12) tick();
        chk("starve_beats", gnt_cnt - g0, GUARD ? 12 / (MAX_WAIT + 1) : 0);
        bus.cpu_req = 0; bus.cpu_we = 0;
        ld_run(0);

        // Reset after two of eight beats.
        d0 = done_cnt; seen = 0;
        ld_start(0, 5'd0, 6'd8, 0);
        for (int i = 0; i < 20 && seen < 2; i++) begin
            @(negedge clk);
            if (bus.ld_gnt) seen++;
            tick();
        end
        chk("beats_before_reset", seen, 2);
        rst = 0;
        repeat (2) tick();
        rst = 1;
        repeat (4) tick();
        chk("no_done_after_reset", done_cnt - d0, 0);
        burst(0, 5'd4, 6'd3, 0, 0);

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 3))
                0: cpu_op(1, 5'($urandom), 8'($urandom));
                1: cpu_op(0, 5'($urandom), 8'h00);
                2: burst(1, 5'($urandom), 6'($urandom_range(0, 10)), 0, 0);
                default: burst(0, 5'($urandom), 6'($urandom_range(0, 12)), 0, 1);
            endcase
        end
        for (int a = 0; a < N; a += 4) cpu_op(0, 5'(a), 8'h00);
        repeat (3) tick();
        chk("cpu_exp_drained", cpu_exp.size(), 0);
        chk("ld_exp_drained", ld_data_q.size() + beat_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
